fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
// - Parametrised instruction-fetch front end that owns the shared instruction ROM port; it is the next generation of the PC block.
// - Keeps a fetch PC and prefetches into a DEPTH-entry instruction queue, which the ID stage drains with a valid/ready handshake.
// - EX data accesses to ROM (load/store) have priority. Because the queue keeps feeding ID, ROM structural conflicts no longer force ID to stall.
// - Sits between CTRL/ID/EX and the ROM. Replaces the PC register plus PC_ROM_OP muxing.
// PARAMETERS
// ADDR_W    32  ROM address width (byte address, word aligned)
// DATA_W    32  instruction/data word width
// DEPTH     4   instruction queue entries; power of 2, >= 2
// RESET_PC  0   first fetch address after reset
// PORTS
// clk            in   1       clock, rising edge
// rst            in   1       asynchronous, active-low reset
// flush_i        in   1       CTRL redirect; highest priority
// new_pc_i       in   ADDR_W  flush target
// branch_i       in   1       ID taken-branch redirect
// branch_pc_i    in   ADDR_W  branch target
// inst_valid_o   out  1       queue head valid
// inst_o         out  DATA_W  head instruction
// inst_pc_o      out  ADDR_W  head instruction address
// id_ready_i     in   1       ID accepts head (pop when valid & ready)
// ex_req_i       in   1       EX ROM access request; held until ex_ack_o
// ex_we_i        in   1       1 = write, 0 = read
// ex_addr_i      in   ADDR_W  data access address
// ex_wdata_i     in   DATA_W  write data
// ex_ack_o       out  1       access presented to ROM this cycle
// ex_rdata_o     out  DATA_W  read data; valid while ex_ack_o & !ex_we_i
// rom_ce_o       out  1       ROM chip enable
// rom_we_o       out  1       ROM write enable
// rom_addr_o     out  ADDR_W  ROM address
// rom_wdata_o    out  DATA_W  ROM write data
// rom_rdata_i    in   DATA_W  ROM read data; combinational for the current rom_addr_o
// BEHAVIOUR
// - Reset (async, rst=0): rom_ce_o=0, rom_we_o=0, rom_addr_o=RESET_PC, rom_wdata_o=0, ex_ack_o=0.
//   Also on reset: queue empty (inst_valid_o=0), no fetch in flight, fetch_pc=RESET_PC.
// - All ROM-side outputs and ex_ack_o are registered. ex_rdata_o = rom_rdata_i (combinational).
// - Port owner per edge, priority data > fetch:
//   DATA:  ex_req_i=1 and ex_ack_o=0. Load rom_addr_o=ex_addr_i, rom_we_o=ex_we_i, rom_wdata_o=ex_wdata_i, rom_ce_o=1; ex_ack_o<=1.
//          A request is never re-sampled in its ack cycle, so at most one data access per 2 cycles.
//   FETCH: otherwise, when count + inflight < DEPTH. Load rom_addr_o=fetch_pc, rom_we_o=0, rom_ce_o=1, inflight<=1; fetch_pc += 4.
//   IDLE:  rom_ce_o<=0, rom_we_o<=0, inflight<=0.
// - An in-flight fetch is pushed at the next edge as {rom_rdata_i, its pc}, unless it has been killed.
// - Redirect: target = flush_i ? new_pc_i : branch_pc_i.
//   At the redirect edge: queue cleared, in-flight fetch killed, fetch_pc <= target.
//   If the port is free at that edge, target is issued the same edge (fetch_pc <= target+4). First inst_valid_o appears one edge later.
//   If a data access wins the edge, the fetch of target issues at the next free edge.
// - A pop and a push at the same edge: count is unchanged. A redirect overrides both.
// - count is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
// - Queue full: no fetch issue; the head is held stable while id_ready_i=0.
// - Adder wraps modulo 2^ADDR_W. Misaligned targets are passed through unchanged.
// - Reset asserted mid-access: everything returns to reset values immediately; any pending ex request is dropped without ack.
// STRUCTURE
// - Shared package/defines.vh: ChipEnable/ChipDisable, ROM_OP_READ/ROM_OP_WRITE, port-owner encoding (OWN_IDLE/OWN_FETCH/OWN_DATA).
// - Sub-module inst_fifo: DEPTH x (DATA_W+ADDR_W) circular buffer with push/pop/clear, count, and full/empty flags.
// - Top level holds the arbiter, fetch_pc, in-flight tracking and the redirect kill logic.
// TESTING
// 1 Reset release, id_ready_i=1 -> rom_addr_o 0,4,8 on consecutive edges; inst_pc_o 0,4,8 starting 2 edges after release.
// 2 id_ready_i=0 for 10 cycles -> exactly DEPTH=4 entries held; rom_ce_o=0 once count+inflight=4; head pc 0 stable.
// 3 ex_req_i read addr 0x100 while streaming -> rom_addr_o=0x100 for one cycle, ex_ack_o=1, ex_rdata_o=ROM[0x100]; fetch resumes at skipped pc.
// 4 ex write 0x200 data 0xDEADBEEF -> rom_we_o=1 for one cycle; later read of 0x200 returns 0xDEADBEEF.
// 5 flush_i=1 new_pc 0x40 and branch_i=1 branch_pc 0x80 same edge, with fetch in flight -> queue emptied; next inst_pc_o=0x40; no stale pc delivered.
// 6 rst=0 asserted asynchronously during a data access -> all outputs at reset values before the next edge; after release, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit_pkg.sv
// Shared encodings for the fetch queue unit: ROM control levels and the
// port-owner state that the arbiter reports on its debug output.
package fetch_queue_unit_pkg;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic ROM_OP_READ  = 1'b0;
  localparam logic ROM_OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } own_e;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Bus bundle between the fetch queue unit and CTRL/ID/EX plus the ROM port.
// ID handshake: an entry moves when inst_valid_o & id_ready_i at a rising edge;
// valid never depends on ready, and the head stays put while valid & !ready.
interface fetch_queue_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              flush_i;
  logic [ADDR_W-1:0] new_pc_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_pc_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              id_ready_i;
  logic              ex_req_i;
  logic              ex_we_i;
  logic [ADDR_W-1:0] ex_addr_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              ex_ack_o;
  logic [DATA_W-1:0] ex_rdata_o;
  logic              rom_ce_o;
  logic              rom_we_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_wdata_o;
  logic [DATA_W-1:0] rom_rdata_i;

  modport master (
    input  flush_i, new_pc_i, branch_i, branch_pc_i, id_ready_i,
    input  ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i, rom_rdata_i,
    output inst_valid_o, inst_o, inst_pc_o, ex_ack_o, ex_rdata_o,
    output rom_ce_o, rom_we_o, rom_addr_o, rom_wdata_o
  );

  modport slave (
    output flush_i, new_pc_i, branch_i, branch_pc_i, id_ready_i,
    output ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i, rom_rdata_i,
    input  inst_valid_o, inst_o, inst_pc_o, ex_ack_o, ex_rdata_o,
    input  rom_ce_o, rom_we_o, rom_addr_o, rom_wdata_o
  );
endinterface

// File: rtl/fetch_queue_unit_inst_fifo.sv
// Circular instruction buffer of {instruction, pc} entries with synchronous
// clear; clear wins over push and pop in the same cycle.
module fetch_queue_unit_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the ROM port, prefetches into a small queue
// for ID, and yields the port to EX data accesses which always take priority.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_queue_unit_if.master  bus,
  output own_e                dbg_owner_o
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + ADDR_W;

  logic              rom_ce;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;
  logic              ex_ack;
  logic              inflight;
  logic [ADDR_W-1:0] fetch_pc;
  own_e              owner;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] issue_pc;
  logic              data_go;
  logic              room;
  logic              fetch_go;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic [ENTRY_W-1:0] head;

  assign redirect = bus.flush_i | bus.branch_i;
  assign target   = bus.flush_i ? bus.new_pc_i : bus.branch_pc_i;
  // A request is ignored in its own ack cycle, so back-to-back EX traffic
  // still leaves every other edge for instruction fetch.
  assign data_go  = bus.ex_req_i & ~ex_ack;
  assign room     = !full && ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));
  // A redirect empties the queue at this edge, so room is guaranteed.
  assign fetch_go = !data_go && (redirect || room);
  assign issue_pc = redirect ? target : fetch_pc;
  // While a fetch is in flight rom_addr still holds its pc.
  assign push     = inflight & ~redirect;
  assign pop      = ~empty & bus.id_ready_i & ~redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_ce    <= CHIP_DISABLE;
      rom_we    <= ROM_OP_READ;
      rom_addr  <= RESET_PC;
      rom_wdata <= '0;
      ex_ack    <= 1'b0;
      inflight  <= 1'b0;
      fetch_pc  <= RESET_PC;
      owner     <= OWN_IDLE;
    end else begin
      ex_ack <= data_go;
      if (data_go) begin
        owner     <= OWN_DATA;
        rom_ce    <= CHIP_ENABLE;
        rom_we    <= bus.ex_we_i ? ROM_OP_WRITE : ROM_OP_READ;
        rom_addr  <= bus.ex_addr_i;
        rom_wdata <= bus.ex_wdata_i;
        inflight  <= 1'b0;
        if (redirect) fetch_pc <= target;
      end else if (fetch_go) begin
        owner    <= OWN_FETCH;
        rom_ce   <= CHIP_ENABLE;
        rom_we   <= ROM_OP_READ;
        rom_addr <= issue_pc;
        inflight <= 1'b1;
        fetch_pc <= issue_pc + ADDR_W'(4);
      end else begin
        owner    <= OWN_IDLE;
        rom_ce   <= CHIP_DISABLE;
        rom_we   <= ROM_OP_READ;
        inflight <= 1'b0;
      end
    end
  end

  fetch_queue_unit_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_data ({bus.rom_rdata_i, rom_addr}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.inst_valid_o = ~empty;
  assign bus.inst_o       = head[ENTRY_W-1:ADDR_W];
  assign bus.inst_pc_o    = head[ADDR_W-1:0];
  assign bus.ex_ack_o     = ex_ack;
  assign bus.ex_rdata_o   = bus.rom_rdata_i;
  assign bus.rom_ce_o     = rom_ce;
  assign bus.rom_we_o     = rom_we;
  assign bus.rom_addr_o   = rom_addr;
  assign bus.rom_wdata_o  = rom_wdata;
  assign dbg_owner_o      = owner;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a behavioural ROM, an instruction scoreboard
// keyed on expected pcs, and a data-access scoreboard for EX traffic.
module tb_fetch_queue_unit;
  import fetch_queue_unit_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int DW     = 1 + ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  own_e dbg_owner;

  fetch_queue_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_queue_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_owner_o (dbg_owner)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM model ----------------
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  logic              w_valid = 1'b0;
  logic [ADDR_W-1:0] w_addr  = '0;
  logic [DATA_W-1:0] w_data  = '0;

  always @(posedge clk) begin
    if (bus.rom_ce_o && bus.rom_we_o) begin
      w_valid <= 1'b1;
      w_addr  <= bus.rom_addr_o;
      w_data  <= bus.rom_wdata_o;
    end
  end

  assign bus.rom_rdata_i = (w_valid && bus.rom_addr_o == w_addr) ? w_data
                                                                  : inst_of(bus.rom_addr_o);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int issues   = 0;
  int pops     = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [DW-1:0]     dexp_q[$];
  logic [ADDR_W-1:0] mon_pc;
  logic [DW-1:0]     mon_d;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_stream(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.rom_ce_o && !bus.ex_ack_o) issues++;
      if (bus.inst_valid_o && bus.id_ready_i && !bus.flush_i && !bus.branch_i) begin
        pops++;
        check("inst_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_pc = exp_q.pop_front();
          check("inst_pc", bus.inst_pc_o, mon_pc);
          check("inst_word", bus.inst_o, inst_of(mon_pc));
        end
      end
      if (bus.ex_ack_o) begin
        check("ex_expected", 64'(dexp_q.size() != 0), 64'd1);
        if (dexp_q.size() != 0) begin
          mon_d = dexp_q.pop_front();
          check("ex_rom_ce", bus.rom_ce_o, 1);
          check("ex_rom_addr", bus.rom_addr_o, mon_d[DW-2:DATA_W]);
          check("ex_rom_we", bus.rom_we_o, mon_d[DW-1]);
          check("ex_owner", dbg_owner, OWN_DATA);
          if (mon_d[DW-1]) check("ex_wdata", bus.rom_wdata_o, mon_d[DATA_W-1:0]);
          else             check("ex_rdata", bus.ex_rdata_o, mon_d[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ex_start(input logic we, input logic [31:0] addr, input logic [31:0] data);
    dexp_q.push_back({we, addr, data});
    bus.ex_req_i   = 1'b1;
    bus.ex_we_i    = we;
    bus.ex_addr_i  = addr;
    bus.ex_wdata_i = we ? data : $urandom;
  endtask

  task automatic ex_access(input logic we, input logic [31:0] addr, input logic [31:0] data);
    logic got;
    got = 1'b0;
    ex_start(we, addr, data);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.ex_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    check("ex_ack_seen", got, 1);
    bus.ex_req_i = 1'b0;
    tick(1);
    check("ex_ack_one_cycle", bus.ex_ack_o, 0);
    check("rom_we_one_cycle", bus.rom_we_o, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rom_ce"}, bus.rom_ce_o, 0);
    check({tag, "_rom_we"}, bus.rom_we_o, 0);
    check({tag, "_rom_addr"}, bus.rom_addr_o, 32'h0);
    check({tag, "_rom_wdata"}, bus.rom_wdata_o, 32'h0);
    check({tag, "_ex_ack"}, bus.ex_ack_o, 0);
    check({tag, "_inst_valid"}, bus.inst_valid_o, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.flush_i     = 1'b0;
    bus.new_pc_i    = '0;
    bus.branch_i    = 1'b0;
    bus.branch_pc_i = '0;
    bus.id_ready_i  = 1'b1;
    bus.ex_req_i    = 1'b0;
    bus.ex_we_i     = 1'b0;
    bus.ex_addr_i   = '0;
    bus.ex_wdata_i  = '0;

    // reset state and streaming start
    tick(3);
    check_reset_values("reset");
    expect_stream(32'h0, 64);
    rst = 1'b1;
    tick(1);
    check("start_rom_addr0", bus.rom_addr_o, 32'h0);
    check("start_rom_ce", bus.rom_ce_o, 1);
    tick(1);
    check("start_rom_addr4", bus.rom_addr_o, 32'h4);
    check("start_valid", bus.inst_valid_o, 1);
    check("start_pc0", bus.inst_pc_o, 32'h0);
    tick(1);
    check("start_rom_addr8", bus.rom_addr_o, 32'h8);
    check("start_pc4", bus.inst_pc_o, 32'h4);
    tick(1);
    check("start_pc8", bus.inst_pc_o, 32'h8);

    // ID stalls: queue fills to DEPTH, fetching stops, head holds
    bus.id_ready_i = 1'b0;
    tick(10);
    check("stall_rom_ce", bus.rom_ce_o, 0);
    check("stall_valid", bus.inst_valid_o, 1);
    check("stall_head_pc", bus.inst_pc_o, exp_q[0]);
    check("stall_head_word", bus.inst_o, inst_of(exp_q[0]));
    check("stall_occupancy", 64'(issues - pops), 64'(DEPTH));

    // EX read and write stealing the port while streaming
    bus.id_ready_i = 1'b1;
    tick(3);
    ex_access(1'b0, 32'h100, inst_of(32'h100));
    tick(4);
    ex_access(1'b1, 32'h200, 32'hDEAD_BEEF);
    tick(2);
    ex_access(1'b0, 32'h200, 32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++) begin
      bus.id_ready_i = 1'($urandom_range(0, 1));
      tick(1);
    end
    bus.id_ready_i = 1'b1;
    tick(4);

    // flush and branch together: flush target wins, in-flight fetch killed
    bus.flush_i     = 1'b1;
    bus.new_pc_i    = 32'h40;
    bus.branch_i    = 1'b1;
    bus.branch_pc_i = 32'h80;
    expect_stream(32'h40, 32);
    tick(1);
    bus.flush_i  = 1'b0;
    bus.branch_i = 1'b0;
    check("flush_empty", bus.inst_valid_o, 0);
    check("flush_rom_addr", bus.rom_addr_o, 32'h40);
    tick(1);
    check("flush_valid", bus.inst_valid_o, 1);
    check("flush_pc", bus.inst_pc_o, 32'h40);
    tick(5);

    // branch while EX wins the same edge: target fetch one edge later
    ex_start(1'b0, 32'h104, inst_of(32'h104));
    bus.branch_i    = 1'b1;
    bus.branch_pc_i = 32'h300;
    expect_stream(32'h300, 32);
    tick(1);
    bus.branch_i = 1'b0;
    bus.ex_req_i = 1'b0;
    check("brdata_ack", bus.ex_ack_o, 1);
    check("brdata_empty", bus.inst_valid_o, 0);
    tick(1);
    check("brdata_rom_addr", bus.rom_addr_o, 32'h300);
    check("brdata_still_empty", bus.inst_valid_o, 0);
    tick(1);
    check("brdata_pc", bus.inst_pc_o, 32'h300);
    tick(5);

    // address wrap and a misaligned target
    bus.flush_i  = 1'b1;
    bus.new_pc_i = 32'hFFFF_FFF8;
    expect_stream(32'hFFFF_FFF8, 32);
    tick(1);
    bus.flush_i = 1'b0;
    check("wrap_rom_addr", bus.rom_addr_o, 32'hFFFF_FFF8);
    tick(8);
    bus.branch_i    = 1'b1;
    bus.branch_pc_i = 32'h42;
    expect_stream(32'h42, 32);
    tick(1);
    bus.branch_i = 1'b0;
    check("misalign_rom_addr", bus.rom_addr_o, 32'h42);
    tick(1);
    check("misalign_pc", bus.inst_pc_o, 32'h42);
    tick(5);

    // asynchronous reset in the middle of a data access
    bus.ex_req_i   = 1'b1;
    bus.ex_we_i    = 1'b0;
    bus.ex_addr_i  = 32'h108;
    tick(1);
    check("rst_mid_ack", bus.ex_ack_o, 1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    tick(1);
    check("rst_req_dropped", bus.ex_ack_o, 0);
    tick(1);
    check("rst_req_dropped2", bus.ex_ack_o, 0);
    bus.ex_req_i = 1'b0;
    exp_q.delete();
    dexp_q.delete();
    expect_stream(32'h0, 32);
    rst = 1'b1;
    tick(1);
    check("restart_rom_addr", bus.rom_addr_o, 32'h0);
    check("restart_ex_ack", bus.ex_ack_o, 0);
    tick(1);
    check("restart_valid", bus.inst_valid_o, 1);
    check("restart_pc", bus.inst_pc_o, 32'h0);
    tick(6);

    check("ex_scoreboard_drained", 64'(dexp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
